stream_fifo: RTL

Parametrised synchronous FIFO with valid/ready streaming handshake on both sides. It is the next generation of the team's simple push/pop FIFO and adds:
- configurable width and depth
- a true occupancy count (no aliasing at full)
- programmable almost-full/almost-empty flags
- synchronous flush
- sticky overflow/underflow error flags
- an optional registered output stage

It sits between user-project stream producers/consumers (e.g. Wishbone-to-AXI-Stream bridges, accelerator input/output buffering).

---
 rtl/stream_fifo_pkg.sv | 17 +
 rtl/stream_fifo_outreg.sv | 62 ++++++
 rtl/stream_fifo.sv | 138 +++++++++++++
 3 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared width helpers and pointer arithmetic for the stream_fifo slice.
// Pointer wrap is explicit, so any DEPTH >= 2 is legal.
package stream_fifo_pkg;

  function automatic int addr_w(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 32'sd2);
  endfunction

  function automatic int next_idx(input int idx, input int depth);
    return (idx == depth - 32'sd1) ? 32'sd0 : idx + 32'sd1;
  endfunction

endpackage

// File: rtl/stream_fifo_outreg.sv
// Output register stage for stream_fifo (REG_OUT=1): holds the head word in a
// flop and decides between bypass from the input and refill from the array.
module stream_fifo_outreg
  import stream_fifo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] in_data,
  input  logic              arr_empty,
  input  logic [DATA_W-1:0] arr_head,
  output logic              arr_wr,
  output logic              arr_rd,
  output logic              oreg_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              bypass_s;

  // An incoming word skips the array only when nothing older is stored there.
  assign bypass_s   = push & arr_empty & (~valid_q | pop);
  assign arr_rd     = pop & ~arr_empty;
  assign arr_wr     = push & ~bypass_s;
  assign oreg_valid = valid_q;
  assign out_data   = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (bypass_s) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (arr_rd) begin
      valid_d = 1'b1;
      data_d  = arr_head;
    end else if (pop) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {DATA_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/stream_fifo.sv
// Parametrised valid/ready stream FIFO with true occupancy, almost flags,
// synchronous flush, sticky error flags and an optional registered output.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int REG_OUT  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(DEPTH+2)-1:0]  level,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int LVL_W  = lvl_w(DEPTH);
  localparam int CAP    = DEPTH + ((REG_OUT != 0) ? 1 : 0);
  localparam logic [LVL_W-1:0] CAP_L = LVL_W'(CAP);
  localparam logic [LVL_W-1:0] AF_L  = LVL_W'(AF_LEVEL);
  localparam logic [LVL_W-1:0] AE_L  = LVL_W'(AE_LEVEL);
  localparam logic [LVL_W-1:0] ONE_L = {{(LVL_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              push_s, pop_s;
  logic              arr_wr_s, arr_rd_s;
  logic [DATA_W-1:0] arr_head_s;

  // in_ready depends only on stored level, never on out_ready.
  assign in_ready     = (level_q < CAP_L);
  assign out_valid    = (level_q != {LVL_W{1'b0}});
  assign push_s       = in_valid & in_ready & ~flush;
  assign pop_s        = out_ready & out_valid & ~flush;
  assign arr_head_s   = mem_q[rd_ptr_q];
  assign level        = level_q;
  assign almost_full  = (level_q >= AF_L);
  assign almost_empty = (level_q <= AE_L);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic oreg_valid_s;
      logic arr_empty_s;

      // Words in the array = level minus the one held in the output flop.
      assign arr_empty_s = (level_q == {{(LVL_W-1){1'b0}}, oreg_valid_s});

      stream_fifo_outreg #(
        .DATA_W (DATA_W)
      ) u_outreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (push_s),
        .pop        (pop_s),
        .in_data    (in_data),
        .arr_empty  (arr_empty_s),
        .arr_head   (arr_head_s),
        .arr_wr     (arr_wr_s),
        .arr_rd     (arr_rd_s),
        .oreg_valid (oreg_valid_s),
        .out_data   (out_data)
      );
    end else begin : g_comb_out
      assign arr_wr_s = push_s;
      assign arr_rd_s = pop_s;
      assign out_data = arr_head_s;
    end
  endgenerate

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = {ADDR_W{1'b0}};
      rd_ptr_d    = {ADDR_W{1'b0}};
      level_d     = {LVL_W{1'b0}};
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      wr_ptr_d    = arr_wr_s ? ADDR_W'(next_idx(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
      rd_ptr_d    = arr_rd_s ? ADDR_W'(next_idx(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
      overflow_d  = overflow_q | (in_valid & ~in_ready);
      underflow_d = underflow_q | (out_ready & ~out_valid);
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + ONE_L;
        2'b01:   level_d = level_q - ONE_L;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= {ADDR_W{1'b0}};
      rd_ptr_q    <= {ADDR_W{1'b0}};
      level_q     <= {LVL_W{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is deliberately not reset; validity is tracked by level.
  always_ff @(posedge clk) begin
    if (arr_wr_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule
